sb_tx_arbiter: RTL
==================

Name: sb_tx_arbiter

Overview:
- Shares the single sideband transmit serializer (the sbtx byte path, clocked by sb_clk) among three requesters: LT (link-training/lane transactions), AT_RSP (register-access responses) and AT_CMD (register-access commands).
- Streams whole packets byte-by-byte and enforces an idle gap between packets.
- Truncates over-long packets and prevents AT_CMD starvation.
- Sits between the logical-layer sideband transaction generators and the sideband serializer.

Parameters:
- GAP_CYCLES, 2: minimum idle sb_clk cycles between packets; legal range 1..15.
- MAX_BYTES, 16: maximum bytes forwarded per packet.
- STARVE_LIMIT, 4: consecutive arbitration losses by a pending AT_CMD before it is promoted to top priority.

Ports:
- sb_clk  in  1  sideband clock
- rst  in  1  synchronous, active-high reset
- sb_en  in  1  transmit enable; low blocks new grants
- req_valid  in  3  per-requester byte valid; bit0=LT, bit1=AT_RSP, bit2=AT_CMD
- req_data  in  24  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  3  per-requester last byte of packet
- req_ready  out  3  per-requester byte accepted
- tx_data  out  8  byte to serializer
- tx_valid  out  1  byte valid to serializer
- tx_last  out  1  last byte of packet
- tx_ready  in  1  serializer accepts byte
- grant  out  3  one-hot owner, 0 when none
- busy  out  1  state is not IDLE
- err_overlen  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- Reset (synchronous): state IDLE; grant=0; busy=0; err_overlen=0; byte and gap counters 0; starve counter 0. tx_valid, tx_last and req_ready are 0 whenever grant=0. A reset asserted mid-packet abandons the packet; the partial packet is not completed.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - If sb_en=1 and any req_valid bit is set, register grant and go to XFER on the next edge. This gives 1 cycle from request to the first tx_valid.
  - Priority is LT > AT_RSP > AT_CMD.
  - Exception: if the starve counter equals STARVE_LIMIT and req_valid[2]=1, AT_CMD wins.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each grant decision where req_valid[2]=1 and AT_CMD loses.
  - Clears when AT_CMD is granted.
  - Holds otherwise.
- XFER:
  - Combinational pass-through from the granted requester g: tx_data=req_data[g], tx_valid=req_valid[g], req_ready[g]=tx_ready. All other req_ready bits are 0.
  - tx_last=req_last[g], OR forced to 1 when the byte counter equals MAX_BYTES-1.
  - The byte counter increments on each handshake (tx_valid & tx_ready).
  - Handshake with req_last[g]=1: go to GAP.
  - Handshake on byte MAX_BYTES with req_last[g]=0: pulse err_overlen and go to DRAIN.
- DRAIN:
  - tx_valid=0; req_ready[g]=1; bytes from g are discarded.
  - The discarded byte with req_last[g]=1 moves the state to GAP. grant stays g during DRAIN.
- GAP:
  - grant=0; gap counter counts GAP_CYCLES cycles, then return to IDLE.
  - Arbitration occurs only in IDLE, so back-to-back packets are separated by exactly GAP_CYCLES+1 cycles with no tx_valid.
- sb_en deassertion:
  - Mid-packet: the packet completes, including DRAIN and GAP.
  - In IDLE: no grant is made.
- Simultaneous requests are resolved only by priority. A requester dropping req_valid mid-packet stalls the transfer; it is never aborted.
- tx_ready low stalls the transfer with no timeout.

Decomposition:
- Package sb_arb_pkg holds:
  - the state enum (IDLE, XFER, DRAIN, GAP);
  - requester index constants REQ_LT=0, REQ_AT_RSP=1, REQ_AT_CMD=2;
  - byte width SB_BYTE_W=8.
- One natural sub-module: sb_prio_sel, a combinational priority/promotion picker. Inputs: req_valid and starve_promote. Output: one-hot grant.

Test Plan:
- Single LT packet of 3 bytes (0xA1, 0xA2, 0xA3, last on byte 3), tx_ready=1 -> grant=001 one cycle after req; tx_valid for 3 cycles; tx_last on 0xA3; then 2 gap cycles with grant=0.
- LT and AT_CMD requesting together, LT re-requesting continuously -> AT_CMD loses 4 times, then wins the 5th arbitration; starve counter returns to 0.
- AT_RSP packet of 20 bytes with no early last -> 16 bytes forwarded, tx_last on byte 16, err_overlen pulses once; bytes 17..20 consumed with tx_valid=0; GAP is entered after byte 20.
- tx_ready toggling 1,0,0,1 during an AT_RSP packet -> no bytes lost or duplicated; tx_data held while stalled.
- sb_en dropped during byte 2 of a 4-byte LT packet -> packet completes; no new grant while sb_en=0 even with all req_valid=111.
- rst pulsed mid-XFER -> next cycle grant=0, busy=0, err_overlen=0, all req_ready=0; arbitration restarts cleanly.

Source files
------------

// File: rtl/sb_tx_arbiter_pkg.sv
// Shared types and constants for the sideband transmit arbiter.
package sb_arb_pkg;

    localparam int SB_BYTE_W  = 8;
    localparam int NUM_REQ    = 3;

    // Requester slots on the req_* buses
    localparam int REQ_LT     = 0;
    localparam int REQ_AT_RSP = 1;
    localparam int REQ_AT_CMD = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sb_tx_arbiter_prio_sel.sv
// Combinational grant picker: fixed LT > AT_RSP > AT_CMD priority, except
// that a starved AT_CMD jumps to the front when promotion is flagged.
import sb_arb_pkg::*;

module sb_prio_sel (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               starve_promote,
    output logic [NUM_REQ-1:0] grant
);

    // One-hot selection of the winning requester
    always_comb begin
        grant = '0;
        if (starve_promote && req_valid[REQ_AT_CMD]) begin
            grant[REQ_AT_CMD] = 1'b1;
        end else if (req_valid[REQ_LT]) begin
            grant[REQ_LT] = 1'b1;
        end else if (req_valid[REQ_AT_RSP]) begin
            grant[REQ_AT_RSP] = 1'b1;
        end else if (req_valid[REQ_AT_CMD]) begin
            grant[REQ_AT_CMD] = 1'b1;
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband transmit arbiter: grants the serializer to one requester per
// packet, streams bytes through combinationally, truncates long packets and
// inserts an idle gap between packets.
import sb_arb_pkg::*;

module sb_tx_arbiter #(
    parameter int GAP_CYCLES   = 2,
    parameter int MAX_BYTES    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         sb_clk,
    input  logic                         rst,
    input  logic                         sb_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SB_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [SB_BYTE_W-1:0]         tx_data,
    output logic                         tx_valid,
    output logic                         tx_last,
    input  logic                         tx_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         err_overlen
);

    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t           state_reg,      state_next;
    logic [NUM_REQ-1:0]   grant_reg,      grant_next;
    logic [BCW-1:0]       byte_cnt_reg,   byte_cnt_next;
    logic [3:0]           gap_cnt_reg,    gap_cnt_next;
    logic [SCW-1:0]       starve_cnt_reg, starve_cnt_next;
    logic                 err_reg,        err_next;

    logic [NUM_REQ-1:0]   pick_grant;
    logic                 starve_promote;
    logic [SB_BYTE_W-1:0] masked_data [NUM_REQ];
    logic [SB_BYTE_W-1:0] sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 in_xfer;
    logic                 in_drain;
    logic                 at_max;
    logic                 handshake;

    assign starve_promote = (starve_cnt_reg == SCW'(STARVE_LIMIT));

    sb_prio_sel u_prio_sel (
        .req_valid      (req_valid),
        .starve_promote (starve_promote),
        .grant          (pick_grant)
    );

    // Isolate the granted requester's byte; grant_reg is one-hot or zero
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = grant_reg[gi] ? req_data[gi*SB_BYTE_W +: SB_BYTE_W] : '0;
        end
    endgenerate

    // OR-reduce the masked bytes into the selected byte
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    assign sel_valid = |(grant_reg & req_valid);
    assign sel_last  = |(grant_reg & req_last);
    assign in_xfer   = (state_reg == XFER);
    assign in_drain  = (state_reg == DRAIN);
    assign at_max    = (byte_cnt_reg == BCW'(MAX_BYTES - 1));
    assign handshake = in_xfer & sel_valid & tx_ready;

    // Serializer-side outputs: live pass-through only while transferring
    assign tx_valid    = in_xfer & sel_valid;
    assign tx_data     = in_xfer ? sel_data : '0;
    assign tx_last     = in_xfer & (sel_last | at_max);
    assign grant       = grant_reg;
    assign busy        = (state_reg != IDLE);
    assign err_overlen = err_reg;

    // Requester ready: follows tx_ready in XFER, forced high while draining
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_reg[gi] & ((in_xfer & tx_ready) | in_drain);
        end
    endgenerate

    // Next-state, counter and starvation bookkeeping
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        byte_cnt_next   = byte_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sb_en && (|req_valid)) begin
                    grant_next    = pick_grant;
                    byte_cnt_next = '0;
                    state_next    = XFER;
                    if (pick_grant[REQ_AT_CMD]) begin
                        starve_cnt_next = '0;
                    end else if (req_valid[REQ_AT_CMD] && !starve_promote) begin
                        starve_cnt_next = starve_cnt_reg + SCW'(1);
                    end
                end
            end
            XFER: begin
                if (handshake) begin
                    byte_cnt_next = byte_cnt_reg + BCW'(1);
                    if (sel_last) begin
                        grant_next   = '0;
                        gap_cnt_next = '0;
                        state_next   = GAP;
                    end else if (at_max) begin
                        err_next   = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sel_valid && sel_last) begin
                    grant_next   = '0;
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            byte_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            byte_cnt_reg   <= byte_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            err_reg        <= err_next;
        end
    end

endmodule
